sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Arbitrates one asynchronous 32-bit SRAM between two requesters: instruction fetch (IF) and the memory stage (fed by the execute stage's mem_op/mem_addr/mem_data).
- Sequences multi-cycle SRAM read/write strobes, performs byte-lane steering for LB/SB, and raises a pipeline stall until the pending access is acknowledged.
- Sits between the pipeline and the board SRAM pins.

Parameters:
- ADDR_W, 20, SRAM word-address width; sram_addr = byte_addr[ADDR_W+1:2].
- WAIT_CYCLES, 1, extra SRAM cycles per access; must be >= 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction-fetch request; held stable until if_ack.
- if_addr  in  32  fetch byte address; word-aligned.
- if_rdata  out  32  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- mem_op  in  8  MEM_NOP/MEM_LB/MEM_LW/MEM_SB/MEM_SW; held stable until mem_ack.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  store data; byte in [7:0] for SB.
- mem_rdata  out  32  load result; valid while mem_ack=1.
- mem_ack  out  1  one-cycle data completion pulse.
- stall_o  out  1  pipeline freeze request.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- sram_data_oe  out  1  drive enable for the bidirectional pad (at top level).
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.
- sram_be_n  out  4  active-low byte enables.

Behaviour:
- Reset (rst=0, async): state IDLE.
  - sram_ce_n/oe_n/we_n = 1, sram_be_n = 4'hF, sram_data_oe = 0.
  - sram_addr, sram_wdata, if_rdata, mem_rdata = 0.
  - if_ack, mem_ack = 0; stall_o = 0.
  - Reset mid-access aborts immediately; no ack is issued.
- FSM states: IDLE, READ, WRITE, DONE. All SRAM outputs are registered.
- IDLE arbitration:
  - A data request (mem_op != MEM_NOP) has fixed priority over if_req.
  - Unknown mem_op codes are treated as NOP.
  - The winner's address, op, and source are latched on the same edge that enters the next state.
  - LB/LW/IF go to READ; SB/SW go to WRITE.
- READ: lasts WAIT_CYCLES+1 cycles.
  - ce_n=0, oe_n=0, be_n=0000, data_oe=0.
  - On the last cycle sram_rdata is captured; then go to DONE.
- WRITE: lasts WAIT_CYCLES+2 cycles.
  - ce_n=0 and data_oe=1 throughout.
  - we_n=0 in all cycles except the first (setup) and last (hold).
  - Then go to DONE.
- DONE: one cycle.
  - Strobes deasserted; ack pulses for the latched source; always returns to IDLE.
  - Requests still visible during DONE are not re-sampled, so no duplicate access occurs.
- Latency from request sampled in IDLE to ack:
  - Read: WAIT_CYCLES+2 cycles.
  - Write: WAIT_CYCLES+3 cycles.
  - Minimum spacing between accesses is one IDLE cycle after DONE.
- Byte-lane rules (b = addr[1:0]):
  - LB: mem_rdata = sign-extend(word[8b+7:8b]).
  - SB: sram_be_n = ~(4'b0001 << b); sram_wdata = {4{mem_wdata[7:0]}}.
  - LW/SW/IF: addr[1:0] ignored; be_n = 0000.
- Stall: stall_o = rst & ((mem_op!=NOP & ~mem_ack) | (if_req & ~if_ack)). Combinational; deasserts in the ack cycle.
- Simultaneous IF and data requests: data is serviced first; IF starts in the IDLE cycle after the data DONE.
- IF starvation is bounded because the pipeline is stalled while a data request is pending.
- Requester changes its request mid-access: ignored; the latched request completes.

Decomposition:
- include.v holds shared constants:
  - MEM_NOP=8'h00, MEM_LB=8'h01, MEM_LW=8'h02, MEM_SB=8'h03, MEM_SW=8'h04.
  - 2-bit state encodings.
- Sub-module sram_lane: combinational byte-enable/write-replicate/load-extract logic, shared by write and read paths.

Test Plan:
- Reset with WAIT_CYCLES=1, then if_req=1, if_addr=0x00000010, sram_rdata=0xDEADBEEF -> sram_addr=4, ce_n/oe_n low 2 cycles; if_ack with if_rdata=0xDEADBEEF 3 cycles after request; stall_o high until ack cycle.
- MEM_SB at addr 0x00000006, mem_wdata=0x000000A5 -> be_n=1011, sram_wdata=0xA5A5A5A5, we_n low exactly 1 of 3 WRITE cycles; mem_ack at cycle 4.
- MEM_LB at addr 0x00000007, sram_rdata=0x80123456 -> mem_rdata=0xFFFFFF80; at addr 0x00000004 -> 0x00000056.
- if_req and MEM_LW asserted in the same cycle -> data read first, mem_ack; one IDLE cycle; then IF access and if_ack; no duplicate access during DONE.
- rst pulsed low mid-WRITE -> we_n/ce_n high and data_oe=0 immediately; no ack; after release the held request restarts from IDLE.
- mem_op=8'h7F (unknown) with if_req=0 -> no SRAM activity, stall_o=0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared memory-op codes, FSM state encoding and op classification helpers
// for the SRAM arbiter.
package sram_arbiter_pkg;

  localparam logic [7:0] MEM_NOP = 8'h00;
  localparam logic [7:0] MEM_LB  = 8'h01;
  localparam logic [7:0] MEM_LW  = 8'h02;
  localparam logic [7:0] MEM_SB  = 8'h03;
  localparam logic [7:0] MEM_SW  = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Any code outside the known set behaves exactly like MEM_NOP.
  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == MEM_LB) || (op == MEM_LW) || (op == MEM_SB) || (op == MEM_SW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == MEM_SB) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/sram_arbiter_lane.sv
// Byte-lane steering: byte enables and data replication for stores,
// byte selection and sign extension for loads.
module sram_arbiter_lane
  import sram_arbiter_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_n,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0] byte_arr [4];
  logic [7:0] sel_byte;
  logic       is_sb;
  logic       is_lb;

  assign is_sb = (op == MEM_SB);
  assign is_lb = (op == MEM_LB);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_arr[gi] = rword[8*gi +: 8];
      // Only a byte store masks lanes; every other access enables all four.
      assign be_n[gi]     = is_sb && (byte_off != 2'(gi));
    end
  endgenerate

  assign sel_byte  = byte_arr[byte_off];
  assign wdata_rep = is_sb ? {4{wdata[7:0]}} : wdata;
  assign rdata_ext = is_lb ? {{24{sel_byte[7]}}, sel_byte} : rword;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an asynchronous 32-bit SRAM: data stage has
// fixed priority over instruction fetch; all SRAM pins are registered.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic [7:0]        mem_op,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic              stall_o,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(WAIT_CYCLES + 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       op_reg;
  logic [1:0]       off_reg;
  logic             src_mem_reg;

  logic             mem_valid;
  logic [7:0]       lane_op;
  logic [1:0]       lane_off;
  logic [3:0]       lane_be_n;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_rdata;
  logic             unused_addr_bits;

  assign mem_valid = is_mem_op(mem_op);

  // In IDLE the lane logic prepares the incoming store; afterwards it
  // decodes the read data against the latched op and byte offset.
  assign lane_op  = (state_reg == ST_IDLE) ? mem_op        : op_reg;
  assign lane_off = (state_reg == ST_IDLE) ? mem_addr[1:0] : off_reg;

  sram_arbiter_lane u_lane (
    .op        (lane_op),
    .byte_off  (lane_off),
    .wdata     (mem_wdata),
    .rword     (sram_rdata),
    .be_n      (lane_be_n),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  assign stall_o = rst & ((mem_valid & ~mem_ack) | (if_req & ~if_ack));

  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      op_reg       <= MEM_NOP;
      off_reg      <= 2'b00;
      src_mem_reg  <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'hF;
      if_rdata     <= '0;
      mem_rdata    <= '0;
      if_ack       <= 1'b0;
      mem_ack      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (mem_valid) begin
            op_reg      <= mem_op;
            off_reg     <= mem_addr[1:0];
            src_mem_reg <= 1'b1;
            sram_addr   <= mem_addr[ADDR_W+1:2];
            sram_ce_n   <= 1'b0;
            if (is_store(mem_op)) begin
              state_reg    <= ST_WRITE;
              sram_wdata   <= lane_wdata;
              sram_be_n    <= lane_be_n;
              sram_data_oe <= 1'b1;
              sram_we_n    <= 1'b1;
              sram_oe_n    <= 1'b1;
            end else begin
              state_reg <= ST_READ;
              sram_be_n <= 4'h0;
              sram_oe_n <= 1'b0;
            end
          end else if (if_req) begin
            state_reg   <= ST_READ;
            op_reg      <= MEM_LW;
            off_reg     <= 2'b00;
            src_mem_reg <= 1'b0;
            sram_addr   <= if_addr[ADDR_W+1:2];
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b0;
            sram_be_n   <= 4'h0;
          end
        end

        ST_READ: begin
          if (cnt_reg == LAST_RD) begin
            state_reg <= ST_DONE;
            cnt_reg   <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= 4'hF;
            if (src_mem_reg) begin
              mem_rdata <= lane_rdata;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata <= sram_rdata;
              if_ack   <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_WRITE: begin
          if (cnt_reg == LAST_WR) begin
            state_reg    <= ST_DONE;
            cnt_reg      <= '0;
            sram_ce_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'hF;
            sram_data_oe <= 1'b0;
            mem_ack      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            // Strobe low for cycles 1..WAIT_CYCLES; cycle 0 is setup, the last is hold.
            sram_we_n <= (cnt_reg >= LAST_RD);
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          if_ack    <= 1'b0;
          mem_ack   <= 1'b0;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed-vector bench for sram_arbiter with WAIT_CYCLES=1.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic [7:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_o;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_data_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  int lat, ce_lo, oe_lo, we_lo, doe_hi, st_hi;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_o(stall_o),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Steps negedges until an ack is seen, tallying strobe activity on the way.
  task automatic run_until_ack(input int limit);
    lat = -1; ce_lo = 0; oe_lo = 0; we_lo = 0; doe_hi = 0; st_hi = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (!sram_ce_n) begin
        ce_lo++;
        cap_addr  = sram_addr;
        cap_be    = sram_be_n;
        cap_wdata = sram_wdata;
      end
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n) we_lo++;
      if (sram_data_oe) doe_hi++;
      if (stall_o) st_hi++;
      if (if_ack || mem_ack) begin
        lat = c;
        break;
      end
    end
    $display("[TB] txn op=%02h if_req=%0d lat=%0d ce_lo=%0d oe_lo=%0d we_lo=%0d doe=%0d addr=%05h be=%h",
             mem_op, if_req, lat, ce_lo, oe_lo, we_lo, doe_hi, cap_addr, cap_be);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_op = MEM_NOP;
    mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ce_n",  {31'b0, sram_ce_n}, 32'd1);
    check_eq("rst_we_n",  {31'b0, sram_we_n}, 32'd1);
    check_eq("rst_be_n",  {28'b0, sram_be_n}, 32'hF);
    check_eq("rst_oe",    {31'b0, sram_data_oe}, 32'd0);
    check_eq("rst_acks",  {30'b0, if_ack, mem_ack}, 32'd0);
    check_eq("rst_stall", {31'b0, stall_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Instruction fetch
    if_req = 1'b1; if_addr = 32'h10; sram_rdata = 32'hDEADBEEF;
    #1 check_eq("if_stall_req", {31'b0, stall_o}, 32'd1);
    run_until_ack(10);
    check_eq("if_lat",   lat, 3);
    check_eq("if_ce_lo", ce_lo, 2);
    check_eq("if_oe_lo", oe_lo, 2);
    check_eq("if_addr",  {12'b0, cap_addr}, 32'h4);
    check_eq("if_ack",   {31'b0, if_ack}, 32'd1);
    check_eq("if_rdata", if_rdata, 32'hDEADBEEF);
    check_eq("if_stall_hi", st_hi, 2);
    if_req = 1'b0;
    @(negedge clk);
    check_eq("if_idle_ack", {31'b0, if_ack}, 32'd0);

    // Byte store
    mem_op = MEM_SB; mem_addr = 32'h6; mem_wdata = 32'hA5;
    run_until_ack(10);
    check_eq("sb_lat",   lat, 4);
    check_eq("sb_be",    {28'b0, cap_be}, 32'hB);
    check_eq("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    check_eq("sb_we_lo", we_lo, 1);
    check_eq("sb_ce_lo", ce_lo, 3);
    check_eq("sb_doe",   doe_hi, 3);
    check_eq("sb_ack",   {31'b0, mem_ack}, 32'd1);
    mem_op = MEM_NOP;
    @(negedge clk);

    // Byte loads, negative and positive
    mem_op = MEM_LB; mem_addr = 32'h7; sram_rdata = 32'h80123456;
    run_until_ack(10);
    check_eq("lb7_lat",   lat, 3);
    check_eq("lb7_be",    {28'b0, cap_be}, 32'h0);
    check_eq("lb7_rdata", mem_rdata, 32'hFFFFFF80);
    mem_op = MEM_NOP;
    @(negedge clk);
    mem_op = MEM_LB; mem_addr = 32'h4;
    run_until_ack(10);
    check_eq("lb4_rdata", mem_rdata, 32'h00000056);
    check_eq("lb4_addr",  {12'b0, cap_addr}, 32'h1);
    mem_op = MEM_NOP;
    @(negedge clk);

    // Simultaneous requests: data first, request held through DONE
    if_req = 1'b1; if_addr = 32'h20;
    mem_op = MEM_LW; mem_addr = 32'h30; sram_rdata = 32'h11223344;
    run_until_ack(10);
    check_eq("sim_lw_lat",   lat, 3);
    check_eq("sim_mem_ack",  {31'b0, mem_ack}, 32'd1);
    check_eq("sim_if_ack0",  {31'b0, if_ack}, 32'd0);
    check_eq("sim_lw_rdata", mem_rdata, 32'h11223344);
    check_eq("sim_lw_addr",  {12'b0, cap_addr}, 32'hC);
    sram_rdata = 32'h55667788;
    @(negedge clk);
    check_eq("sim_gap_ce_n", {31'b0, sram_ce_n}, 32'd1);
    check_eq("sim_gap_ack",  {31'b0, mem_ack}, 32'd0);
    mem_op = MEM_NOP;
    run_until_ack(10);
    check_eq("sim_if_lat",   lat, 3);
    check_eq("sim_if_ack",   {31'b0, if_ack}, 32'd1);
    check_eq("sim_if_rdata", if_rdata, 32'h55667788);
    check_eq("sim_if_addr",  {12'b0, cap_addr}, 32'h8);
    if_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a word store
    mem_op = MEM_SW; mem_addr = 32'h40; mem_wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    check_eq("rw_we_pre", {31'b0, sram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rw_we_n", {31'b0, sram_we_n}, 32'd1);
    check_eq("rw_ce_n", {31'b0, sram_ce_n}, 32'd1);
    check_eq("rw_doe",  {31'b0, sram_data_oe}, 32'd0);
    check_eq("rw_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    check_eq("rw_no_ack", {31'b0, mem_ack}, 32'd0);
    rst = 1'b1;
    run_until_ack(10);
    check_eq("rw_lat",   lat, 4);
    check_eq("rw_wdata", cap_wdata, 32'h12345678);
    check_eq("rw_be",    {28'b0, cap_be}, 32'h0);
    check_eq("rw_we_lo", we_lo, 1);
    mem_op = MEM_NOP;
    @(negedge clk);

    // Unknown op code behaves as NOP
    mem_op = 8'h7F; mem_addr = 32'h80;
    ce_lo = 0; st_hi = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!sram_ce_n) ce_lo++;
      if (stall_o) st_hi++;
    end
    $display("[TB] txn op=7f idle_cycles=4 ce_lo=%0d stall=%0d", ce_lo, st_hi);
    check_eq("unk_ce_lo", ce_lo, 0);
    check_eq("unk_stall", st_hi, 0);
    mem_op = MEM_NOP;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
